transmissor_medida_16: RTL

Serial transmitter that sends one 16-bit measurement word as two back-to-back UART frames (8 data bits, parity, 1 stop bit). It sits on the sensor-side board, directly upstream of the measurement receiver in the DHT11 interface, and drives the line that receiver samples on `rx_serial`. The high byte is sent first, then the low byte. The receiver reassembles the word in the same order.

---
 rtl/transmissor_medida_16.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/transmissor_medida_16.sv
// UART transmitter for one 2*N_BITS measurement word: high byte frame, then low byte frame.
// Optional macro TRANSMISSOR_ESPACO_EN inserts one idle-high bit time between the two frames.
module transmissor_medida_16 #(
    parameter int BAUD_RATE = 9600,
    parameter int CLOCK_HZ  = 50_000_000,
    parameter int N_BITS    = 8,
    parameter int PARITY    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  partida,
    input  logic [2*N_BITS-1:0]   dados,
    output logic                  tx_serial,
    output logic                  ocupado,
    output logic                  pronto,
    output logic [2:0]            db_estado
);

    localparam int CICLOS_BIT = CLOCK_HZ / BAUD_RATE;
    localparam int CNT_W      = (CICLOS_BIT > 1) ? $clog2(CICLOS_BIT) : 1;
    localparam int QUADRO_W   = N_BITS + 3;
    localparam int BIT_W      = $clog2(QUADRO_W);
    localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(CICLOS_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_FIM = BIT_W'(QUADRO_W - 1);
    localparam logic [CNT_W-1:0] CNT_UM  = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_UM  = BIT_W'(1);

    typedef enum logic [2:0] {
        INICIAL   = 3'b000,
        TRANSMITE = 3'b001,
        ESPACO    = 3'b010,
        FINAL     = 3'b011
    } estado_t;

    estado_t estado, estado_prox;

    logic [CNT_W-1:0]    cnt_ciclos;
    logic [BIT_W-1:0]    idx_bit;
    logic                idx_byte;
    logic [QUADRO_W-1:0] quadro;
    logic [N_BITS-1:0]   byte_baixo;
    logic                fim_bit;
    logic                fim_quadro;

    function automatic logic paridade(input logic [N_BITS-1:0] b);
        return (^b) ^ (PARITY == 1);
    endfunction

    // Frame is shifted out LSB first: start, data, parity, stop.
    function automatic logic [QUADRO_W-1:0] monta_quadro(input logic [N_BITS-1:0] b);
        return {1'b1, paridade(b), b, 1'b0};
    endfunction

    assign fim_bit    = (cnt_ciclos == CNT_FIM);
    assign fim_quadro = (idx_bit == BIT_FIM);
    assign db_estado  = estado;

    always_ff @(posedge clock) begin
        if (reset) estado <= INICIAL;
        else       estado <= estado_prox;
    end

    always_comb begin
        estado_prox = estado;
        tx_serial   = 1'b1;
        ocupado     = 1'b0;
        pronto      = 1'b0;
        case (estado)
            INICIAL: begin
                if (partida) estado_prox = TRANSMITE;
            end
            TRANSMITE: begin
                tx_serial = quadro[0];
                ocupado   = 1'b1;
                if (fim_bit && fim_quadro) begin
                    if (idx_byte) estado_prox = FINAL;
`ifdef TRANSMISSOR_ESPACO_EN
                    else          estado_prox = ESPACO;
`endif
                end
            end
`ifdef TRANSMISSOR_ESPACO_EN
            ESPACO: begin
                ocupado = 1'b1;
                if (fim_bit) estado_prox = TRANSMITE;
            end
`endif
            FINAL: begin
                ocupado     = 1'b1;
                pronto      = 1'b1;
                estado_prox = INICIAL;
            end
            default: estado_prox = INICIAL;
        endcase
    end

    // Bit timing, frame shift register and byte sequencing.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_ciclos <= '0;
            idx_bit    <= '0;
            idx_byte   <= 1'b0;
            quadro     <= '0;
            byte_baixo <= '0;
        end else begin
            case (estado)
                INICIAL: begin
                    cnt_ciclos <= '0;
                    idx_bit    <= '0;
                    if (partida) begin
                        quadro     <= monta_quadro(dados[2*N_BITS-1:N_BITS]);
                        byte_baixo <= dados[N_BITS-1:0];
                        idx_byte   <= 1'b0;
                    end
                end
                TRANSMITE: begin
                    if (fim_bit) begin
                        cnt_ciclos <= '0;
                        if (fim_quadro) begin
                            idx_bit <= '0;
                            if (!idx_byte) begin
                                idx_byte <= 1'b1;
`ifndef TRANSMISSOR_ESPACO_EN
                                quadro   <= monta_quadro(byte_baixo);
`endif
                            end
                        end else begin
                            idx_bit <= idx_bit + BIT_UM;
                            quadro  <= {1'b1, quadro[QUADRO_W-1:1]};
                        end
                    end else begin
                        cnt_ciclos <= cnt_ciclos + CNT_UM;
                    end
                end
`ifdef TRANSMISSOR_ESPACO_EN
                ESPACO: begin
                    if (fim_bit) begin
                        cnt_ciclos <= '0;
                        quadro     <= monta_quadro(byte_baixo);
                    end else begin
                        cnt_ciclos <= cnt_ciclos + CNT_UM;
                    end
                end
`endif
                default: begin
                    cnt_ciclos <= '0;
                    idx_bit    <= '0;
                end
            endcase
        end
    end

endmodule
